// File: rtl/msgbus_arbiter.sv
// Round-robin arbiter sharing one message-bus send channel among NUM_PORTS
// requesters. The winning request is captured into output registers, held on
// the bus until bus_ack_i, then acknowledged back to its requester for one cycle.
module msgbus_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_PORTS-1:0]    req_val_i,
    output logic [NUM_PORTS-1:0]    req_ack_o,
    input  logic [NUM_PORTS*32-1:0] req_dst_i,
    input  logic [NUM_PORTS*32-1:0] req_tag_i,
    input  logic [NUM_PORTS*64-1:0] req_msg_i,
    output logic                    bus_val_o,
    input  logic                    bus_ack_i,
    output logic [31:0]             bus_dst_o,
    output logic [31:0]             bus_tag_o,
    output logic [63:0]             bus_msg_o,
    output logic [IDX_W-1:0]        grant_id_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [31:0]      dst_q, dst_d;
    logic [31:0]      tag_q, tag_d;
    logic [63:0]      msg_q, msg_d;

    logic             any_req;
    logic [IDX_W-1:0] gnt_sel;
    logic [IDX_W-1:0] cand;

    // Rotating priority search: scan from rr_ptr upward (wrapping); walking the
    // rotation backwards lets the closest set bit to rr_ptr overwrite the rest.
    always_comb begin
        any_req = |req_val_i;
        gnt_sel = '0;
        cand    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (req_val_i[cand]) begin
                gnt_sel = cand;
            end
        end
    end

    // Next-state logic: grant only from IDLE, hold in SEND until the bus acks,
    // spend exactly one cycle in ACK so the requester can drop its request.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        dst_d    = dst_q;
        tag_d    = tag_q;
        msg_d    = msg_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d  = gnt_sel;
                    dst_d    = req_dst_i[32*gnt_sel +: 32];
                    tag_d    = req_tag_i[32*gnt_sel +: 32];
                    msg_d    = req_msg_i[64*gnt_sel +: 64];
                    rr_ptr_d = (gnt_sel == IDX_W'(NUM_PORTS - 1)) ? '0 : gnt_sel + 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (bus_ack_i) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-message registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            dst_q    <= '0;
            tag_q    <= '0;
            msg_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            dst_q    <= dst_d;
            tag_q    <= tag_d;
            msg_q    <= msg_d;
        end
    end

    // One-hot completion ack to the granted port, only while in ACK.
    always_comb begin
        req_ack_o = '0;
        if (state_q == ACK) begin
            req_ack_o[grant_q] = 1'b1;
        end
    end

    assign bus_val_o  = (state_q == SEND);
    assign busy_o     = (state_q == SEND) || (state_q == ACK);
    assign grant_id_o = grant_q;
    assign bus_dst_o  = dst_q;
    assign bus_tag_o  = tag_q;
    assign bus_msg_o  = msg_q;

endmodule

// File: doc/msgbus_arbiter.md
Name: msgbus_arbiter

Overview:
- Round-robin arbiter that shares one message-bus send channel (val/ack/dst/tag/msg) among NUM_PORTS xctcmsg instances. Typical use: cores in a cluster that share one bus port.
- Sits between the per-core bus send outputs and the shared bus_communication link.
- Captures the granted request into an output register, holds it on the bus until bus_ack_i, then returns a one-cycle ack to the winning requester.

Parameters:
- NUM_PORTS, 4, number of requesters (>=2).
- IDX_W, $clog2(NUM_PORTS), width of the grant index (derived).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_val_i  input  NUM_PORTS  per-port send request valid.
- req_ack_o  output  NUM_PORTS  per-port one-cycle completion ack.
- req_dst_i  input  NUM_PORTS*32  flattened destinations; port i in bits [32i+31:32i].
- req_tag_i  input  NUM_PORTS*32  flattened tags; same layout as req_dst_i.
- req_msg_i  input  NUM_PORTS*64  flattened payloads; port i in bits [64i+63:64i].
- bus_val_o  output  1  shared bus valid.
- bus_ack_i  input  1  shared bus acknowledge.
- bus_dst_o  output  32  registered destination.
- bus_tag_o  output  32  registered tag.
- bus_msg_o  output  64  registered payload.
- grant_id_o  output  IDX_W  index of the port that owns the bus; valid while bus_val_o=1.
- busy_o  output  1  high in SEND and ACK states.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE, rr_ptr=0.
  - bus_val_o=0, req_ack_o=0, busy_o=0, grant_id_o=0.
  - bus_dst_o, bus_tag_o, bus_msg_o = 0.
- FSM has three states: IDLE, SEND, ACK.
- IDLE:
  - If any req_val_i bit is set, grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_PORTS.
  - Next edge: capture that port's dst/tag/msg into the output registers, set grant_id_o, set rr_ptr=(grant+1) mod NUM_PORTS, go to SEND.
  - No request: stay in IDLE, nothing changes.
- SEND:
  - bus_val_o=1; output registers are held stable.
  - bus_ack_i=1 sampled: go to ACK next edge.
  - Otherwise stay in SEND indefinitely. There is no timeout.
- ACK:
  - req_ack_o[grant_id_o]=1 for exactly this one cycle; bus_val_o=0.
  - Unconditionally go to IDLE next edge.
  - No new grant is evaluated in ACK. This gives the requester one cycle to drop or refresh req_val_i.
- Latency:
  - Request seen in IDLE at cycle t gives bus_val_o=1 at t+1.
  - bus_ack_i at cycle u gives req_ack_o pulse at u+1.
  - Minimum spacing per transaction is 3 cycles (IDLE, SEND, ACK) when the bus acks immediately.
- Requester rules:
  - req_val_i may drop before a grant with no effect.
  - After a grant the captured data is used. Dropping or changing req_val_i or the data before the ack is ignored and the transaction still completes.
  - A requester must not reassert for a new message until after its ack cycle.
- bus_ack_i while bus_val_o=0 (IDLE or ACK) is ignored.
- Only one req_ack_o bit is ever set; it is zero outside ACK.
- Fairness: with all ports requesting continuously, grants go 0,1,2,...,NUM_PORTS-1,0,...
  - No port waits more than NUM_PORTS-1 transactions after its request is first seen in IDLE.
- rr_ptr wraps from NUM_PORTS-1 to 0. Grant search is combinational over one rotation.
- Reset asserted mid-SEND or mid-ACK:
  - bus_val_o and req_ack_o drop immediately.
  - The in-flight transaction is abandoned; the requester receives no ack.
- busy_o=1 exactly when state is SEND or ACK.

Test Plan:
- Reset then idle: all outputs 0. Pulse bus_ack_i=1 with no requests -> no state change, req_ack_o stays 0.
- Single request: port2 req_val=1, dst=0x5, tag=0xA, msg=0x1122334455667788, bus acks on the first SEND cycle -> bus_val_o 1 cycle later, grant_id_o=2, bus fields equal inputs; req_ack_o=4'b0100 pulse for 1 cycle.
- All four ports requesting continuously, bus acks immediately -> grant order 0,1,2,3,0,1. Each transaction takes 3 cycles; exactly one ack per transaction, to the matching port.
- Bus back-pressure: hold bus_ack_i=0 for 10 cycles while port1 changes its msg and drops req_val -> bus_msg_o keeps the captured value, bus_val_o stays 1. Ack arrives -> req_ack_o[1] pulses.
- Pointer wrap: rr_ptr=3 after a port2 grant; ports 0 and 3 then request -> port3 granted first, then port0.
- Async reset in SEND: assert rst mid-cycle -> bus_val_o=0 before the next edge, no req_ack_o. After release, a pending port0 request is granted with rr_ptr=0.
